// File: rtl/vtg_pkg.sv
// Shared types and constants for the video timing generator.
// Pattern logic elsewhere is compiled in only with VTG_PATTERN_EN.
package vtg_pkg;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    RAMP    = 2'd1,
    CHECKER = 2'd2,
    EXT     = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

endpackage

// File: rtl/vtg_pattern.sv
// Combinational test-pattern pixel selection for video_timing_gen.
// Instantiated only when VTG_PATTERN_EN is defined.
module vtg_pattern
  import vtg_pkg::*;
(
  input  pattern_e    pat,
  input  logic [7:0]  h_lsb,
  input  logic [7:0]  v_lsb,
  input  logic [2:0]  bar_idx,
  input  logic [23:0] pix_i,
  output logic [23:0] pix_o
);

  logic [23:0] bar_rgb;
  logic        unused_v;

  assign unused_v = ^{v_lsb[7:4], v_lsb[2:0]};

  always_comb begin
    bar_rgb = C_BLACK;
    case (bar_idx)
      3'd0:    bar_rgb = C_WHITE;
      3'd1:    bar_rgb = C_YELLOW;
      3'd2:    bar_rgb = C_CYAN;
      3'd3:    bar_rgb = C_GREEN;
      3'd4:    bar_rgb = C_MAGENTA;
      3'd5:    bar_rgb = C_RED;
      3'd6:    bar_rgb = C_BLUE;
      default: bar_rgb = C_BLACK;
    endcase
  end

  always_comb begin
    pix_o = '0;
    case (pat)
      BARS:    pix_o = bar_rgb;
      RAMP:    pix_o = {3{h_lsb}};
      CHECKER: pix_o = (h_lsb[3] ^ v_lsb[3]) ? C_WHITE : C_BLACK;
      default: pix_o = pix_i;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with RGB pixel output and one-cycle pixel request.
// Define VTG_PATTERN_EN to compile in the internal test-pattern generator.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] pix_i,
  output logic        pix_req_o,
  output logic [23:0] rgb_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            running, h_last, v_last, at_origin, active, in_hs, in_vs;
  logic [23:0]     pix_sel;

  assign running   = (state_q != IDLE);
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign in_vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign pix_req_o = running && active;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                  state_d = RUN;
        else if (h_last && v_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (!running) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

`ifdef VTG_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  pattern_e      pat_q, pat_cur;
  logic [BW-1:0] bar_pix;
  logic [2:0]    bar_idx;
  logic [7:0]    h_lsb, v_lsb;

  // The origin pixel must already use the newly latched selection.
  assign pat_cur = (running && at_origin) ? pattern_e'(pattern_sel) : pat_q;
  assign h_lsb   = 8'(h_cnt);
  assign v_lsb   = 8'(v_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= BARS;
      bar_pix <= '0;
      bar_idx <= '0;
    end else begin
      if (running && at_origin) pat_q <= pattern_e'(pattern_sel);
      if (!running || h_last) begin
        bar_pix <= '0;
        bar_idx <= '0;
      end else if (h_cnt < H_ACT) begin
        if (bar_pix == BW'(BAR_W - 1)) begin
          bar_pix <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pix <= bar_pix + 1'b1;
        end
      end
    end
  end

  vtg_pattern u_pattern (
    .pat     (pat_cur),
    .h_lsb   (h_lsb),
    .v_lsb   (v_lsb),
    .bar_idx (bar_idx),
    .pix_i   (pix_i),
    .pix_o   (pix_sel)
  );
`else
  logic [1:0] unused_sel;
  assign unused_sel = pattern_sel;
  assign pix_sel    = pix_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_o       <= '0;
      dv_o        <= 1'b0;
      hs_o        <= ~HS_POL;
      vs_o        <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      rgb_o       <= pix_req_o ? pix_sel : '0;
      dv_o        <= pix_req_o;
      hs_o        <= (running && in_hs) ? HS_POL : ~HS_POL;
      vs_o        <= (running && in_vs) ? VS_POL : ~VS_POL;
      frame_start <= running && at_origin;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench for video_timing_gen on an 8x4 active raster
// (14 x 7 total, 98 cycles per frame).
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] pix_i = '0;
  logic        pix_req_o, dv_o, hs_o, vs_o, frame_start;
  logic [23:0] rgb_o;

  int errors = 0;
  int checks = 0;
  int pcnt   = 0;

  video_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pattern_sel (pattern_sel),
    .pix_i       (pix_i),
    .pix_req_o   (pix_req_o),
    .rgb_o       (rgb_o),
    .dv_o        (dv_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %06h want %06h", tag, obs, exp);
    end
  endtask

  // External source: pixel index within the frame, one per request.
  task automatic tick();
    if (pix_req_o === 1'b1) begin
      pix_i = 24'(pcnt % 32);
      pcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_rgb(input int pat, input int h, input int v);
    int p;
    p = pat;
`ifndef VTG_PATTERN_EN
    p = 3;
`endif
    case (p)
      0: begin
        case (h)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return {3{8'(h)}};
      2: return ((((h >> 3) ^ (v >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'(v * 8 + h);
    endcase
  endfunction

  // Starts at the sample showing a frame's first output; checks n samples.
  task automatic check_frame(input int pat, input int n, input int chg_k,
                             input logic [1:0] chg_sel, input int en0_k, input int en1_k);
    int h, v, c, dvs, hss, vss;
    bit act, req;
    dvs = 0; hss = 0; vss = 0;
    for (int k = 0; k < n; k++) begin
      h = k % 14;
      v = k / 14;
      act = (h < 8) && (v < 4);
      chk($sformatf("dv k%0d", k), 24'(dv_o), 24'(act));
      chk($sformatf("hs k%0d", k), 24'(hs_o), 24'((h >= 10) && (h < 12)));
      chk($sformatf("vs k%0d", k), 24'(vs_o), 24'(v == 5));
      chk($sformatf("fs k%0d", k), 24'(frame_start), 24'(k == 0));
      chk($sformatf("rgb k%0d", k), rgb_o, act ? exp_rgb(pat, h, v) : 24'h0);
      if (k < 97) begin
        c = k + 1;
        req = ((c % 14) < 8) && ((c / 14) < 4);
        chk($sformatf("req k%0d", k), 24'(pix_req_o), 24'(req));
      end
      dvs += int'(dv_o);
      hss += int'(hs_o);
      vss += int'(vs_o);
      if (k == chg_k) pattern_sel = chg_sel;
      if (k == en0_k) en = 1'b0;
      if (k == en1_k) en = 1'b1;
      tick();
    end
    if (n == 98) begin
      chk("dv per frame", 24'(dvs), 24'd32);
      chk("hs per frame", 24'(hss), 24'd14);
      chk("vs per frame", 24'(vss), 24'd14);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rgb"}, rgb_o, 24'h0);
    chk({tag, " dv"}, 24'(dv_o), 24'h0);
    chk({tag, " fs"}, 24'(frame_start), 24'h0);
    chk({tag, " req"}, 24'(pix_req_o), 24'h0);
    chk({tag, " hs"}, 24'(hs_o), 24'h0);
    chk({tag, " vs"}, 24'(vs_o), 24'h0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 chk_reset_vals("por");
    #19 rst = 1'b1;

    repeat (3) begin
      tick();
      chk("idle dv", 24'(dv_o), 24'h0);
      chk("idle req", 24'(pix_req_o), 24'h0);
      chk("idle hs", 24'(hs_o), 24'h0);
    end

    en = 1'b1;
    tick();
    chk("start req", 24'(pix_req_o), 24'h1);
    chk("start dv", 24'(dv_o), 24'h0);
    chk("start fs", 24'(frame_start), 24'h0);
    tick();

    check_frame(0, 98, -1, 2'd0, -1, -1);
    check_frame(0, 98, 20, 2'd1, -1, -1);
    check_frame(1, 98, 20, 2'd3, -1, -1);
    check_frame(3, 98, -1, 2'd3, 14, -1);

    repeat (4) begin
      chk("drained dv", 24'(dv_o), 24'h0);
      chk("drained req", 24'(pix_req_o), 24'h0);
      chk("drained fs", 24'(frame_start), 24'h0);
      tick();
    end

    en = 1'b1;
    tick();
    chk("restart req", 24'(pix_req_o), 24'h1);
    tick();
    check_frame(3, 98, -1, 2'd3, 10, 96);
    check_frame(3, 98, -1, 2'd3, -1, -1);
    check_frame(3, 33, -1, 2'd3, -1, -1);

    chk("pre-reset dv", 24'(dv_o), 24'h1);
    #2 rst = 1'b0;
    pix_i = '0;
    pcnt = 0;
    #1 chk_reset_vals("midline");
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst req", 24'(pix_req_o), 24'h1);
    chk("post-rst dv", 24'(dv_o), 24'h0);
    tick();
    check_frame(3, 98, -1, 2'd3, -1, -1);

    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Video stream transmitter that generates the raster timing consumed by the grayscale converter and every other pixel-stream sink in the pipeline. It produces 24-bit RGB pixels with `dv`/`hs`/`vs` qualifiers from parameterised horizontal and vertical timing. Pixels come from an internal test-pattern generator or from an upstream pixel source through a one-cycle request handshake. It sits at the head of the video path, in front of `rgb2y`-style consumers.

## Interface
- `H_ACTIVE`, 1280: active pixels per line; must be a multiple of 8.
- `H_FP`, 110 / `H_SYNC`, 40 / `H_BP`, 220: horizontal front porch, sync and back porch, in pixels.
- `V_ACTIVE`, 720: active lines per frame.
- `V_FP`, 5 / `V_SYNC`, 5 / `V_BP`, 20: vertical porches and sync, in lines.
- `HS_POL`, 1 / `VS_POL`, 1: asserted level of `hs_o` and `vs_o`.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request.
- `pattern_sel`  in  2  pixel source: 0 colour bars, 1 gray ramp, 2 checkerboard, 3 external.
- `pix_i`  in  24  external pixel {R,G,B}, sampled in the cycle `pix_req_o` is high.
- `pix_req_o`  out  1  external pixel request.
- `rgb_o`  out  24  pixel {R[23:16], G[15:8], B[7:0]}.
- `dv_o` / `hs_o` / `vs_o`  out  1  data valid, horizontal sync, vertical sync.
- `frame_start`  out  1  one-cycle pulse coincident with the first active pixel of each frame.

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`, `V_TOTAL` defined likewise. Counter widths are `$clog2` of each total.
- `h_cnt` runs 0..H_TOTAL-1 and wraps to 0. `v_cnt` advances on each `h_cnt` wrap and wraps to 0 after V_TOTAL-1.
- Region order on each axis: active, front porch, sync, back porch.
- Active pixel when `h_cnt<H_ACTIVE && v_cnt<V_ACTIVE`.
- `hs` is asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). `vs` is asserted for whole lines with `v_cnt` in the vertical sync range.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0,0; outputs idle. Moves to RUN when `en`=1.
  - RUN: counters advance. Moves to DRAIN when `en`=0.
  - DRAIN: counters advance. Returns to RUN if `en`=1. Goes to IDLE on the cycle `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1, so a frame is always completed.
  - If `en` is high in that same last cycle of DRAIN, RUN takes priority and the next frame starts with no gap.
- `pix_req_o` = (state≠IDLE) && active. It is combinational from registered state, with no dependence on `pix_i`.
- `pattern_sel` is latched only while counters are at 0,0 and state≠IDLE, i.e. once per frame. Mid-frame changes take effect at the next frame.
- Patterns:
  - Colour bars: 8 bars of H_ACTIVE/8 pixels, in order white, yellow, cyan, green, magenta, red, blue, black, using channel levels 0xFF/0x00. The bar index comes from a bar-pixel counter; no divider.
  - Gray ramp: R=G=B=`h_cnt[7:0]`.
  - Checkerboard: white when `h_cnt[3]^v_cnt[3]`, black otherwise.
  - External: `pix_i`.
- Outside the active region `rgb_o` = 0.

## Timing
- Reset values: `rgb_o`=0, `dv_o`=0, `frame_start`=0, `pix_req_o`=0, `hs_o`=!HS_POL, `vs_o`=!VS_POL, state IDLE, counters 0.
- Reset asserted mid-frame clears everything asynchronously. After release, the block restarts from the top of frame.
- All outputs except `pix_req_o` are registered, with latency 1 from the counter cycle. The sync qualifiers and pixel data share this latency, so they stay aligned.
- If the edge at cycle t samples `en`=1 in IDLE, then `pix_req_o` is high during cycle t+1, and `dv_o`, `frame_start` and the first pixel appear after the edge that ends cycle t+1.
- `pix_i` is captured on the edge that ends a `pix_req_o`-high cycle. It appears on `rgb_o` with `dv_o` in the following cycle.

## Configuration
- `VTG_PATTERN_EN` defined: internal pattern generator and `pattern_sel` latch are compiled in.
- Not defined: the pattern logic is removed, `pattern_sel` is ignored, and `rgb_o` always carries `pix_i` during active pixels.

## Structure
- Package `vtg_pkg` holds:
  - the `pattern_e` enum (BARS, RAMP, CHECKER, EXT);
  - the `state_e` enum (IDLE, RUN, DRAIN);
  - the 8 bar colour constants as 24-bit localparams.
- Sub-module `vtg_pattern`: pure combinational pixel selection from `h_cnt`, `v_cnt`, bar index and the latched pattern. It is only instantiated under `VTG_PATTERN_EN`.

## Test plan
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1.
- `en`=1 for 2 frames: 32 `dv_o` cycles per 98-cycle frame; `hs_o` high 2 cycles every 14; `vs_o` high for 14 cycles starting at line 5; one `frame_start` per frame.
- Bars, external mode off: line 0 `rgb_o` = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Pattern 3 with `pix_i`=count incremented on each `pix_req_o`: `rgb_o` sequence 0..31 per frame, each value exactly one cycle after its request.
- `en` dropped at line 1: frame completes, then IDLE with `dv_o`=0. `en` re-raised in the last drain cycle: next `frame_start` follows with no gap.
- `pattern_sel` changed 0→1 mid-frame: current frame stays bars; next frame ramps 00..07.
- `rst` asserted mid-line: all outputs take their reset values immediately; the first `dv_o` after release lands 2 cycles after `en` is sampled.
